storage_mgmt_rr: RTL and testbench

Multi-reader, single-writer storage pool with round-robin read arbitration and a registered read port. It replaces the fixed-priority, combinational-read storage manager. Any number of requesters (fetch, load/store, debug) share one read port without starvation. Writes come from a single owner, typically the writeback/store path.

---
 rtl/storage_mgmt_rr.sv | 94 +++++++++
 tb/tb_storage_mgmt_rr.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/storage_mgmt_rr.sv
// Shared storage pool: one writer, AMT_READER round-robin readers, registered read port.
// Optional write-first bypass on same-cycle read/write collision: STORAGE_MGMT_RR_WR_FWD_EN.
module storage_mgmt_rr #(
   parameter int READ_ADDR_SIZE = 10,
   parameter int ROW_WIDTH      = 32,
   parameter int AMT_READER     = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [READ_ADDR_SIZE*AMT_READER-1:0] readAddrs,
   input  logic [AMT_READER-1:0]                readReqs,
   input  logic [READ_ADDR_SIZE-1:0]            writeAddr,
   input  logic [ROW_WIDTH-1:0]                 writeData,
   input  logic                                 writeEn,
   output logic [AMT_READER-1:0]                readGnt,
   output logic [AMT_READER-1:0]                readValid,
   output logic [ROW_WIDTH-1:0]                 poolReadData
);

   localparam int PTR_W = (AMT_READER > 1) ? $clog2(AMT_READER) : 1;
   localparam int DEPTH = 2 ** READ_ADDR_SIZE;

   logic [ROW_WIDTH-1:0]      mem_r [0:DEPTH-1];
   logic [PTR_W-1:0]          rr_ptr_r;
   logic [AMT_READER-1:0]     gnt_s;
   logic [PTR_W-1:0]          gnt_idx_s;
   logic [PTR_W-1:0]          next_ptr_s;
   logic [READ_ADDR_SIZE-1:0] gnt_addr_s;
   logic [ROW_WIDTH-1:0]      rd_data_s;

   // Round-robin search starting at rr_ptr_r; first requesting reader wins.
   always_comb begin
      logic             found_v;
      logic [PTR_W-1:0] idx_v;
      found_v   = 1'b0;
      idx_v     = '0;
      gnt_s     = '0;
      gnt_idx_s = '0;
      for (int k = 0; k < AMT_READER; k++) begin
         idx_v = PTR_W'((int'(rr_ptr_r) + k) % AMT_READER);
         if (!found_v && rst && readReqs[idx_v]) begin
            found_v      = 1'b1;
            gnt_s[idx_v] = 1'b1;
            gnt_idx_s    = idx_v;
         end else begin
            found_v = found_v;
         end
      end
   end

   // Pointer advance, granted address select and read data source.
   always_comb begin
      if (gnt_idx_s == PTR_W'(AMT_READER - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = gnt_idx_s + PTR_W'(1);
      end
      gnt_addr_s = readAddrs[int'(gnt_idx_s)*READ_ADDR_SIZE +: READ_ADDR_SIZE];
`ifdef STORAGE_MGMT_RR_WR_FWD_EN
      if (writeEn && (writeAddr == gnt_addr_s)) begin
         rd_data_s = writeData;
      end else begin
         rd_data_s = mem_r[gnt_addr_s];
      end
`else
      rd_data_s = mem_r[gnt_addr_s];
`endif
   end

   assign readGnt = gnt_s;

   // Storage array; reset does not inhibit or clear writes.
   always_ff @(posedge clk) begin
      if (writeEn) begin
         mem_r[writeAddr] <= writeData;
      end
   end

   // Arbiter pointer and registered read port.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_r     <= '0;
         readValid    <= '0;
         poolReadData <= '0;
      end else if (|gnt_s) begin
         rr_ptr_r     <= next_ptr_s;
         readValid    <= gnt_s;
         poolReadData <= rd_data_s;
      end else begin
         readValid    <= '0;
      end
   end

endmodule

// File: tb/tb_storage_mgmt_rr.sv
// Bench for storage_mgmt_rr: directed vector table, corner sequences, random vs. reference model.
module tb_storage_mgmt_rr;

   logic        clk;
   logic        rst;
   logic [39:0] readAddrs;
   logic [3:0]  readReqs;
   logic [9:0]  writeAddr;
   logic [31:0] writeData;
   logic        writeEn;
   logic [3:0]  readGnt;
   logic [3:0]  readValid;
   logic [31:0] poolReadData;

   int tests = 0;
   int fails = 0;

   storage_mgmt_rr #(.READ_ADDR_SIZE(10), .ROW_WIDTH(32), .AMT_READER(4)) dut (
      .clk(clk), .rst(rst), .readAddrs(readAddrs), .readReqs(readReqs),
      .writeAddr(writeAddr), .writeData(writeData), .writeEn(writeEn),
      .readGnt(readGnt), .readValid(readValid), .poolReadData(poolReadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int          m_ptr = 0;
   logic [31:0] m_mem [0:1023];
   logic [3:0]  m_valid = 4'b0000;
   logic [31:0] m_data  = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant(input logic r, input logic [3:0] q);
      if (!r) return -1;
      for (int k = 0; k < 4; k++) begin
         if (q[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
   endfunction

   // One clock: drive, check grant mid-cycle, check registered outputs after the edge.
   task automatic apply(input logic r, input logic [3:0] q, input logic [39:0] a,
                        input logic we, input logic [9:0] wa, input logic [31:0] wd,
                        input logic use_tbl, input logic [3:0] tbl_gnt);
      int          g;
      logic [3:0]  eg;
      logic [9:0]  ra;
      logic [31:0] rd;
      rst = r; readReqs = q; readAddrs = a; writeEn = we; writeAddr = wa; writeData = wd;
      #3;
      g  = model_grant(r, q);
      eg = (g < 0) ? 4'b0000 : (4'b0001 << g);
      chk("grant_model", {28'h0, readGnt}, {28'h0, eg});
      if (use_tbl) chk("grant_table", {28'h0, readGnt}, {28'h0, tbl_gnt});
      rd = 32'h0;
      if (g >= 0) begin
         ra = a[g*10 +: 10];
`ifdef STORAGE_MGMT_RR_WR_FWD_EN
         rd = (we && wa == ra) ? wd : m_mem[ra];
`else
         rd = m_mem[ra];
`endif
      end
      @(posedge clk);
      #1;
      if (we) m_mem[wa] = wd;
      if (!r) begin
         m_ptr = 0; m_valid = 4'b0000; m_data = 32'h0;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % 4; m_valid = eg; m_data = rd;
      end else begin
         m_valid = 4'b0000;
      end
      chk("valid", {28'h0, readValid}, {28'h0, m_valid});
      chk("data", poolReadData, m_data);
   endtask

   typedef struct {
      logic       r;
      logic [3:0] q;
      logic [3:0] gnt;
   } vec_t;

   vec_t tbl [17];
   logic [39:0] base_addrs;
   logic [31:0] exp_col;

   initial begin
      rst = 1'b0; readReqs = 4'b0000; readAddrs = 40'h0;
      writeEn = 1'b0; writeAddr = 10'h0; writeData = 32'h0;

      // Reset with all requesting; rows 0..15 are written during reset.
      for (int i = 0; i < 16; i++)
         apply(1'b0, 4'b1111, 40'h0, 1'b1, 10'(i), 32'hA000_0000 + 32'(i*17), 1'b1, 4'b0000);

      tbl[0]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[2]  = '{1'b1, 4'b1111, 4'b0100};
      tbl[3]  = '{1'b1, 4'b1111, 4'b1000};
      tbl[4]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[5]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[6]  = '{1'b1, 4'b1111, 4'b0100};
      tbl[7]  = '{1'b1, 4'b1111, 4'b1000};
      tbl[8]  = '{1'b1, 4'b0001, 4'b0001};
      tbl[9]  = '{1'b1, 4'b1001, 4'b1000};
      tbl[10] = '{1'b1, 4'b1001, 4'b0001};
      tbl[11] = '{1'b1, 4'b0000, 4'b0000};
      tbl[12] = '{1'b1, 4'b0110, 4'b0010};
      tbl[13] = '{1'b1, 4'b0100, 4'b0100};
      tbl[14] = '{1'b1, 4'b0100, 4'b0100};
      tbl[15] = '{1'b0, 4'b0100, 4'b0000};
      tbl[16] = '{1'b1, 4'b0110, 4'b0010};
      base_addrs = {10'd11, 10'd10, 10'd9, 10'd8};
      for (int i = 0; i < 17; i++)
         apply(tbl[i].r, tbl[i].q, base_addrs, 1'b0, 10'h0, 32'h0, 1'b1, tbl[i].gnt);

      // Write then read the same row next cycle.
      apply(1'b1, 4'b0000, 40'h0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 4'b0000);
      apply(1'b1, 4'b0100, {10'd0, 10'd5, 10'd0, 10'd0}, 1'b0, 10'h0, 32'h0, 1'b0, 4'b0000);
      chk("wr_rd_valid", {28'h0, readValid}, 32'h4);
      chk("wr_rd_data", poolReadData, 32'hDEADBEEF);

      // Same-cycle collision on row 7.
      apply(1'b1, 4'b0000, 40'h0, 1'b1, 10'd7, 32'h11, 1'b0, 4'b0000);
      apply(1'b1, 4'b0010, {10'd0, 10'd0, 10'd7, 10'd0}, 1'b1, 10'd7, 32'h22, 1'b0, 4'b0000);
`ifdef STORAGE_MGMT_RR_WR_FWD_EN
      exp_col = 32'h22;
`else
      exp_col = 32'h11;
`endif
      chk("collision_data", poolReadData, exp_col);
      apply(1'b1, 4'b0001, {10'd0, 10'd0, 10'd0, 10'd7}, 1'b0, 10'h0, 32'h0, 1'b0, 4'b0000);
      chk("collision_after", poolReadData, 32'h22);

      // Randomized traffic over rows 0..15 (all initialised).
      for (int n = 0; n < 400; n++) begin
         logic [39:0] ra;
         ra = '0;
         for (int i = 0; i < 4; i++) ra[i*10 +: 10] = 10'($urandom_range(0, 15));
         apply(($urandom_range(0, 19) != 0), 4'($urandom_range(0, 15)), ra,
               1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, 1'b0, 4'b0000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
